// File: rtl/wu_jitter_logger_pkg.sv
// Shared constants and helpers for the wake-up jitter logger.
package wu_jitter_logger_pkg;

  localparam logic        JLOG_SRC_WU  = 1'b0;
  localparam logic        JLOG_SRC_S2  = 1'b1;
  localparam int          JLOG_ENTRY_W = 32;
  localparam logic [30:0] JLOG_SAT_MAX = 31'h7FFF_FFFF;

  // Clamp a 32-bit jitter count into the 31-bit payload of an entry.
  function automatic logic [30:0] sat31(input logic [31:0] d);
    return d[31] ? JLOG_SAT_MAX : d[30:0];
  endfunction

endpackage

// File: rtl/wu_jitter_logger_if.sv
// Capture/drain bus between the measurement source, the host pipe-out and the logger.
interface wu_jitter_logger_if #(
  parameter int ADDR_W = 10
);
  import wu_jitter_logger_pkg::*;

  logic                    s_valid;
  logic                    s_src;
  logic [JLOG_ENTRY_W-1:0] s_data;
  logic                    rd_en;
  logic [JLOG_ENTRY_W-1:0] rd_data;
  logic                    empty;
  logic                    full;
  logic [ADDR_W:0]         level;

  modport master (
    output s_valid, s_src, s_data, rd_en,
    input  rd_data, empty, full, level
  );

  modport slave (
    input  s_valid, s_src, s_data, rd_en,
    output rd_data, empty, full, level
  );

endinterface

// File: rtl/jlog_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port (block RAM).
module jlog_sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reset maps onto the block RAM's synchronous output reset.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wu_jitter_logger.sv
// Per-event jitter capture FIFO with overflow/underflow/drop statistics.
// Optional per-source min/max trackers are enabled by defining JLOG_MINMAX_EN.
module wu_jitter_logger
  import wu_jitter_logger_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DROP_W = 16
) (
  input  logic                 clki,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 clear,
  wu_jitter_logger_if.slave    bus,
  output logic                 ovf,
  output logic                 udf,
  output logic [DROP_W-1:0]    drop_cnt
`ifdef JLOG_MINMAX_EN
  ,
  output logic [30:0]          min_wu,
  output logic [30:0]          max_wu,
  output logic [30:0]          min_s2,
  output logic [30:0]          max_s2
`endif
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              rd_acc, wr_acc, drop;
  logic [JLOG_ENTRY_W-1:0] wr_word;

  assign rd_acc  = bus.rd_en & ~empty_q;
  // A full FIFO still takes a sample when a read frees a slot in the same cycle.
  assign wr_acc  = bus.s_valid & arm & (~full_q | rd_acc);
  assign drop    = bus.s_valid & arm & full_q & ~rd_acc;
  assign wr_word = {bus.s_src, sat31(bus.s_data)};

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
    level_d  = level_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    ovf_d    = ovf_q | drop;
    udf_d    = udf_q | (bus.rd_en & empty_q);
    drop_d   = (drop && (drop_q != {DROP_W{1'b1}})) ? drop_q + DROP_W'(1) : drop_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clki) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      drop_q   <= drop_d;
    end
  end

  // clear discards same-cycle traffic; rd_data keeps its last value through it.
  jlog_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (JLOG_ENTRY_W)
  ) u_ram (
    .clk   (clki),
    .rst_n (reset_n),
    .we    (wr_acc & ~clear),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_word),
    .re    (rd_acc & ~clear),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.empty = empty_q;
  assign bus.full  = full_q;
  assign bus.level = level_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign drop_cnt  = drop_q;

`ifdef JLOG_MINMAX_EN
  logic [30:0] min_wu_q, max_wu_q, min_s2_q, max_s2_q;
  logic [30:0] sample;

  assign sample = wr_word[30:0];

  always_ff @(posedge clki) begin
    if (!reset_n || clear) begin
      min_wu_q <= JLOG_SAT_MAX;
      max_wu_q <= '0;
      min_s2_q <= JLOG_SAT_MAX;
      max_s2_q <= '0;
    end else if (wr_acc) begin
      if (bus.s_src == JLOG_SRC_S2) begin
        if (sample < min_s2_q) min_s2_q <= sample;
        if (sample > max_s2_q) max_s2_q <= sample;
      end else begin
        if (sample < min_wu_q) min_wu_q <= sample;
        if (sample > max_wu_q) max_wu_q <= sample;
      end
    end
  end

  assign min_wu = min_wu_q;
  assign max_wu = max_wu_q;
  assign min_s2 = min_s2_q;
  assign max_s2 = max_s2_q;
`endif

endmodule

// File: tb/tb_wu_jitter_logger.sv
// Directed, table-driven bench for wu_jitter_logger plus multi-cycle fill/clear sequences.
module tb_wu_jitter_logger;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam int NV = 15;

  typedef struct {
    bit          vld;
    bit          src;
    logic [31:0] data;
    bit          rd;
    bit          armv;
    int          lvl;
    bit          emp;
    bit          ful;
    bit          ov;
    bit          ud;
    int          drp;
    bit          chk_rd;
    logic [31:0] rdv;
  } vec_t;

  logic        clki;
  logic        reset_n;
  logic        arm;
  logic        clear;
  logic        ovf;
  logic        udf;
  logic [15:0] drop_cnt;
`ifdef JLOG_MINMAX_EN
  logic [30:0] min_wu, max_wu, min_s2, max_s2;
`endif

  int n_vec;
  int n_err;
  vec_t tbl [NV];

  wu_jitter_logger_if #(.ADDR_W(10)) bus ();

  wu_jitter_logger #(.ADDR_W(10), .DROP_W(16)) dut (
    .clki     (clki),
    .reset_n  (reset_n),
    .arm      (arm),
    .clear    (clear),
    .bus      (bus),
    .ovf      (ovf),
    .udf      (udf),
    .drop_cnt (drop_cnt)
`ifdef JLOG_MINMAX_EN
    ,
    .min_wu   (min_wu),
    .max_wu   (max_wu),
    .min_s2   (min_s2),
    .max_s2   (max_s2)
`endif
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit v, input bit s, input logic [31:0] d,
                     input bit r, input bit c, input bit a);
    bus.s_valid = v;
    bus.s_src   = s;
    bus.s_data  = d;
    bus.rd_en   = r;
    clear       = c;
    arm         = a;
    @(posedge clki);
    #1;
    bus.s_valid = 1'b0;
    bus.rd_en   = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic chk_stat(input string nm, input int lvl, input bit emp, input bit ful,
                          input bit ov, input bit ud, input int drp);
    chk({nm, " level"}, 32'(bus.level), 32'(lvl));
    chk({nm, " empty"}, 32'(bus.empty), 32'(emp));
    chk({nm, " full"},  32'(bus.full),  32'(ful));
    chk({nm, " ovf"},   32'(ovf),       32'(ov));
    chk({nm, " udf"},   32'(udf),       32'(ud));
    chk({nm, " drop"},  32'(drop_cnt),  32'(drp));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //           vld src data          rd arm lvl emp ful ov ud drp chk rdv
    tbl[0]  = '{H, L, 32'd5,          L, H,  1,  L,  L,  L, L, 0,  L, 32'd0};
    tbl[1]  = '{H, L, 32'd7,          L, H,  2,  L,  L,  L, L, 0,  L, 32'd0};
    tbl[2]  = '{H, L, 32'd9,          L, H,  3,  L,  L,  L, L, 0,  L, 32'd0};
    tbl[3]  = '{L, L, 32'd0,          H, H,  2,  L,  L,  L, L, 0,  H, 32'd5};
    tbl[4]  = '{L, L, 32'd0,          H, H,  1,  L,  L,  L, L, 0,  H, 32'd7};
    tbl[5]  = '{L, L, 32'd0,          H, H,  0,  H,  L,  L, L, 0,  H, 32'd9};
    tbl[6]  = '{L, L, 32'd0,          H, H,  0,  H,  L,  L, H, 0,  H, 32'd9};
    tbl[7]  = '{H, H, 32'hFFFF_FFFF,  L, H,  1,  L,  L,  L, H, 0,  L, 32'd0};
    tbl[8]  = '{H, L, 32'd3,          L, L,  1,  L,  L,  L, H, 0,  L, 32'd0};
    tbl[9]  = '{L, L, 32'd0,          H, L,  0,  H,  L,  L, H, 0,  H, 32'hFFFF_FFFF};
    tbl[10] = '{H, L, 32'h8000_0000,  L, H,  1,  L,  L,  L, H, 0,  L, 32'd0};
    tbl[11] = '{L, L, 32'd0,          H, H,  0,  H,  L,  L, H, 0,  H, 32'h7FFF_FFFF};
    tbl[12] = '{H, H, 32'h0000_1234,  L, H,  1,  L,  L,  L, H, 0,  L, 32'd0};
    tbl[13] = '{H, L, 32'h0000_0055,  H, H,  1,  L,  L,  L, H, 0,  H, 32'h8000_1234};
    tbl[14] = '{L, L, 32'd0,          H, H,  0,  H,  L,  L, H, 0,  H, 32'h0000_0055};

    bus.s_valid = 1'b0;
    bus.s_src   = 1'b0;
    bus.s_data  = '0;
    bus.rd_en   = 1'b0;
    clear       = 1'b0;
    arm         = 1'b1;
    reset_n     = 1'b0;
    repeat (2) @(posedge clki);
    #1;
    chk_stat("reset", 0, H, L, L, L, 0);
    chk("reset rd_data", bus.rd_data, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].vld, tbl[i].src, tbl[i].data, tbl[i].rd, L, tbl[i].armv);
      chk_stat($sformatf("v%0d", i), tbl[i].lvl, tbl[i].emp, tbl[i].ful,
               tbl[i].ov, tbl[i].ud, tbl[i].drp);
      if (tbl[i].chk_rd) chk($sformatf("v%0d rd_data", i), bus.rd_data, tbl[i].rdv);
    end

    // clear with level 10 and a concurrent write and read
    for (int i = 0; i < 10; i++) cyc(H, L, 32'(100 + i), L, L, H);
    chk("pre-clear level", 32'(bus.level), 32'd10);
    cyc(H, L, 32'd999, H, H, H);
    chk_stat("clear", 0, H, L, L, L, 0);
    chk("clear rd_data hold", bus.rd_data, 32'h0000_0055);
    cyc(H, L, 32'h42, L, L, H);
    chk("post-clear level", 32'(bus.level), 32'd1);
    cyc(L, L, 32'd0, H, L, H);
    chk("post-clear rd_data", bus.rd_data, 32'h42);
    chk("post-clear empty", 32'(bus.empty), 32'd1);

    // fill to full, then overflow by three
    for (int i = 0; i < 1024; i++) cyc(H, L, 32'(i * 3 + 1), L, L, H);
    chk_stat("filled", 1024, L, H, L, L, 0);
    for (int i = 0; i < 3; i++) cyc(H, L, 32'h0000_DEAD, L, L, H);
    chk_stat("overflow", 1024, L, H, H, L, 3);

    // write and read together while full
    cyc(H, L, 32'h0000_BEEF, H, L, H);
    chk_stat("full r+w", 1024, L, H, H, L, 3);
    chk("full r+w rd_data", bus.rd_data, 32'd1);

    for (int k = 1; k <= 1024; k++) begin
      cyc(L, L, 32'd0, H, L, H);
      chk($sformatf("drain %0d", k), bus.rd_data,
          (k < 1024) ? 32'(k * 3 + 1) : 32'h0000_BEEF);
    end
    chk_stat("drained", 0, H, L, H, L, 3);

`ifdef JLOG_MINMAX_EN
    cyc(L, L, 32'd0, L, H, H);
    cyc(H, L, 32'd40, L, L, H);
    cyc(H, L, 32'd12, L, L, H);
    cyc(H, L, 32'd90, L, L, H);
    cyc(H, H, 32'd3,  L, L, H);
    chk("min_wu", 32'(min_wu), 32'd12);
    chk("max_wu", 32'(max_wu), 32'd90);
    chk("min_s2", 32'(min_s2), 32'd3);
    chk("max_s2", 32'(max_s2), 32'd3);
    cyc(L, L, 32'd0, L, H, H);
    chk("clr min_wu", 32'(min_wu), 32'h7FFF_FFFF);
    chk("clr max_wu", 32'(max_wu), 32'd0);
    chk("clr min_s2", 32'(min_s2), 32'h7FFF_FFFF);
    chk("clr max_s2", 32'(max_s2), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
